// File: rtl/bikers_pkg.sv
// Shared constants for the bike sprite layer path.
package bikers_pkg;

    localparam int unsigned ENEMY_BIKES_COUNT = 8;
    localparam int unsigned BIKE_CHANNELS     = ENEMY_BIKES_COUNT + 1;
    localparam int unsigned PLAYER_CH         = BIKE_CHANNELS - 1;

    localparam logic [7:0] COLOR_TRANSPARENT = 8'hFF;
    localparam logic [7:0] COLOR_BACKGROUND  = 8'hFF;

endpackage

// File: rtl/bikers_prio_enc.sv
// Combinational lowest-index priority encoder with a ">= 2 requests" flag.
module bikers_prio_enc
    import bikers_pkg::*;
#(
    parameter int N  = BIKE_CHANNELS,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic          multi
);

    localparam int unsigned NU = N;

    always_comb begin
        idx = '0;
        // Scan from the top so the lowest set bit is written last.
        for (int unsigned i = NU; i > 0; i--) begin
            if (req[i-1]) begin
                idx = IW'(i - 1);
            end
        end
    end

    assign any   = |req;
    assign multi = (req & (req - N'(1))) != '0;

endmodule

// File: rtl/bikers_layer_mux.sv
// Registered priority mux for bike sprite layers with per-frame overlap flags.
module bikers_layer_mux
    import bikers_pkg::*;
#(
    parameter int                 CHANNELS    = BIKE_CHANNELS,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_TRANSPARENT,
    parameter logic [COLOR_W-1:0] BACKGROUND  = COLOR_BACKGROUND
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              startOfFrame,
    input  logic [CHANNELS-1:0]               channel_en,
    input  logic [CHANNELS-1:0]               inputInsideRectangle,
    input  logic [CHANNELS-1:0][COLOR_W-1:0]  RGBvector,
    output logic [COLOR_W-1:0]                RGBout,
    output logic                              drawingRequest,
    output logic [$clog2(CHANNELS)-1:0]       winner_idx,
    output logic [CHANNELS-1:0]               overlap_frame,
    output logic                              overlap_valid
);

    localparam int          IW = $clog2(CHANNELS);
    localparam int unsigned CU = CHANNELS;

    logic [CHANNELS-1:0] op;
    logic [CHANNELS-1:0] ov;
    logic [CHANNELS-1:0] acc;
    logic                enc_any;
    logic                enc_multi;
    logic [IW-1:0]       enc_idx;

    always_comb begin
        op = '0;
        for (int unsigned i = 0; i < CU; i++) begin
            op[i] = channel_en[i] & inputInsideRectangle[i] &
                    (RGBvector[i] != TRANSPARENT);
        end
    end

    bikers_prio_enc #(
        .N  (CHANNELS),
        .IW (IW)
    ) u_enc (
        .req   (op),
        .any   (enc_any),
        .idx   (enc_idx),
        .multi (enc_multi)
    );

    assign ov = enc_multi ? op : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            RGBout         <= BACKGROUND;
            drawingRequest <= 1'b0;
            winner_idx     <= '0;
            overlap_frame  <= '0;
            overlap_valid  <= 1'b0;
            acc            <= '0;
        end else begin
            RGBout         <= enc_any ? RGBvector[enc_idx] : BACKGROUND;
            drawingRequest <= enc_any;
            winner_idx     <= enc_any ? enc_idx : '0;
            // This cycle's overlap belongs to the frame being closed.
            if (startOfFrame) begin
                overlap_frame <= acc | ov;
                acc           <= '0;
                overlap_valid <= 1'b1;
            end else begin
                acc           <= acc | ov;
                overlap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bikers_layer_mux.sv
// Bench for bikers_layer_mux at 2, 9 and 32 channels sharing one stimulus.
module tb_bikers_layer_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b1;
    logic            sof   = 1'b0;
    logic [31:0]     en    = '1;
    logic [31:0]     ins   = '0;
    logic [31:0][7:0] col  = '0;

    logic [7:0]  rgb_2,  rgb_9,  rgb_32;
    logic        dr_2,   dr_9,   dr_32;
    logic [0:0]  win_2;
    logic [3:0]  win_9;
    logic [4:0]  win_32;
    logic [1:0]  of_2;
    logic [8:0]  of_9;
    logic [31:0] of_32;
    logic        ov_2,   ov_9,   ov_32;

    bikers_layer_mux #(.CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset), .startOfFrame(sof),
        .channel_en(en[1:0]), .inputInsideRectangle(ins[1:0]), .RGBvector(col[1:0]),
        .RGBout(rgb_2), .drawingRequest(dr_2), .winner_idx(win_2),
        .overlap_frame(of_2), .overlap_valid(ov_2));

    bikers_layer_mux #(.CHANNELS(9)) dut9 (
        .clk(clk), .reset(reset), .startOfFrame(sof),
        .channel_en(en[8:0]), .inputInsideRectangle(ins[8:0]), .RGBvector(col[8:0]),
        .RGBout(rgb_9), .drawingRequest(dr_9), .winner_idx(win_9),
        .overlap_frame(of_9), .overlap_valid(ov_9));

    bikers_layer_mux #(.CHANNELS(32)) dut32 (
        .clk(clk), .reset(reset), .startOfFrame(sof),
        .channel_en(en), .inputInsideRectangle(ins), .RGBvector(col),
        .RGBout(rgb_32), .drawingRequest(dr_32), .winner_idx(win_32),
        .overlap_frame(of_32), .overlap_valid(ov_32));

    int n_chk  = 0;
    int n_fail = 0;

    localparam int NS [3] = '{2, 9, 32};

    // Reference state, one entry per channel-count instance.
    logic [7:0]  e_rgb [3];
    logic        e_dr  [3];
    int          e_win [3];
    logic [31:0] e_of  [3];
    logic        e_ov  [3];
    logic [31:0] m_acc [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Computes what the outputs must be after the coming clock edge.
    task automatic model_next();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] op;
            logic [31:0] ovv;
            int          w;
            op = '0;
            for (int i = 0; i < NS[k]; i++)
                op[i] = en[i] && ins[i] && (col[i] != 8'hFF);
            if (reset) begin
                e_rgb[k] = 8'hFF; e_dr[k] = 1'b0; e_win[k] = 0;
                e_of[k] = '0; e_ov[k] = 1'b0; m_acc[k] = '0;
            end else begin
                w = -1;
                for (int i = NS[k] - 1; i >= 0; i--)
                    if (op[i]) w = i;
                if (w >= 0) begin
                    e_rgb[k] = col[w]; e_dr[k] = 1'b1; e_win[k] = w;
                end else begin
                    e_rgb[k] = 8'hFF; e_dr[k] = 1'b0; e_win[k] = 0;
                end
                ovv = ($countones(op) >= 2) ? op : 32'h0;
                if (sof) begin
                    e_of[k] = m_acc[k] | ovv; m_acc[k] = '0; e_ov[k] = 1'b1;
                end else begin
                    m_acc[k] = m_acc[k] | ovv; e_ov[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("rgb_2",   32'(rgb_2),  32'(e_rgb[0]));
        chk("dr_2",    32'(dr_2),   32'(e_dr[0]));
        chk("win_2",   32'(win_2),  32'(e_win[0]));
        chk("of_2",    32'(of_2),   e_of[0]);
        chk("ov_2",    32'(ov_2),   32'(e_ov[0]));
        chk("rgb_9",   32'(rgb_9),  32'(e_rgb[1]));
        chk("dr_9",    32'(dr_9),   32'(e_dr[1]));
        chk("win_9",   32'(win_9),  32'(e_win[1]));
        chk("of_9",    32'(of_9),   e_of[1]);
        chk("ov_9",    32'(ov_9),   32'(e_ov[1]));
        chk("rgb_32",  32'(rgb_32), 32'(e_rgb[2]));
        chk("dr_32",   32'(dr_32),  32'(e_dr[2]));
        chk("win_32",  32'(win_32), 32'(e_win[2]));
        chk("of_32",   of_32,       e_of[2]);
        chk("ov_32",   32'(ov_32),  32'(e_ov[2]));
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        // Reset held with every input active.
        en = '1; ins = '1; sof = 1'b1;
        for (int i = 0; i < 32; i++) col[i] = 8'(i + 1);
        reset = 1'b1;
        repeat (3) step();
        chk("reset_rgb", 32'(rgb_9), 32'hFF);
        chk("reset_dr",  32'(dr_9),  32'h0);
        chk("reset_of",  32'(of_9),  32'h0);
        chk("reset_ov",  32'(ov_9),  32'h0);
        reset = 1'b0; sof = 1'b0; ins = '0;

        // Priority: lowest opaque index wins.
        ins = 32'h106; col[1] = 8'h1C; col[2] = 8'hE0; col[8] = 8'h03;
        step();
        chk("prio_rgb", 32'(rgb_9), 32'h1C);
        chk("prio_win", 32'(win_9), 32'd1);
        ins = 32'h104;
        step();
        chk("prio2_rgb", 32'(rgb_9), 32'hE0);
        chk("prio2_win", 32'(win_9), 32'd2);

        // Transparent colour and disabled channel.
        ins = 32'h9; col[0] = 8'hFF; col[3] = 8'h55;
        step();
        chk("transp_rgb", 32'(rgb_9), 32'h55);
        chk("transp_win", 32'(win_9), 32'd3);
        en[3] = 1'b0;
        step();
        chk("dis_rgb", 32'(rgb_9), 32'hFF);
        chk("dis_dr",  32'(dr_9),  32'h0);
        en = '1;

        // Flush the frame accumulated so far.
        ins = '0; sof = 1'b1; step(); sof = 1'b0; step();

        // Overlap of ch4 and ch8 mid-frame.
        col[4] = 8'h22; col[8] = 8'h33; ins = 32'h110;
        repeat (2) step();
        ins = '0;
        repeat (3) step();
        sof = 1'b1; step(); sof = 1'b0;
        chk("frame_of",  32'(of_9), 32'h110);
        chk("frame_ov",  32'(ov_9), 32'h1);
        step();
        chk("frame_ov_pulse", 32'(ov_9), 32'h0);
        chk("frame_hold",     32'(of_9), 32'h110);
        repeat (4) step();
        sof = 1'b1; step(); sof = 1'b0;
        chk("clean_of", 32'(of_9), 32'h0);

        // Overlap in the startOfFrame cycle belongs to the closing frame.
        col[0] = 8'h10; col[1] = 8'h20; ins = 32'h3; sof = 1'b1;
        step();
        chk("sof_ov_of", 32'(of_9), 32'h3);
        ins = '0; sof = 1'b0;
        repeat (3) step();
        sof = 1'b1; step(); sof = 1'b0;
        chk("sof_ov_next", 32'(of_9), 32'h0);

        // Same overlap with reset asserted: nothing is published.
        ins = 32'h3; sof = 1'b1; reset = 1'b1;
        step();
        chk("rst_sof_of", 32'(of_9), 32'h0);
        chk("rst_sof_ov", 32'(ov_9), 32'h0);
        reset = 1'b0; sof = 1'b0;

        // Reset mid-frame discards accumulated overlap.
        ins = 32'h3; step(); ins = '0;
        reset = 1'b1; step(); reset = 1'b0;
        repeat (2) step();
        sof = 1'b1; step(); sof = 1'b0;
        chk("rst_mid_of", 32'(of_9), 32'h0);

        // Randomized traffic at all three widths.
        for (int c = 0; c < 10000; c++) begin
            en  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'hFFFF_FFFF;
            ins = $urandom() & $urandom();
            for (int i = 0; i < 32; i++)
                col[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom());
            sof   = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
